// File: rtl/hazard_pkg.sv
// hazard_pkg: state encoding, NOP constant and parameter limits shared by the hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int MIN_CYCLES = 1;
  localparam int MAX_CYCLES = 3;
  function automatic int clampCycles(int n);
    return n < MIN_CYCLES ? MIN_CYCLES : n > MAX_CYCLES ? MAX_CYCLES : n;
  endfunction
endpackage

// File: rtl/hazard_cycle_counter.sv
// hazard_cycle_counter: loadable 2-bit down-counter that holds at zero
// Ports: clk/rst_n clock and async active-low reset; load/loadVal load a new count;
//        dec decrements when not loading; count is the current value; zero flags count==0.
module hazard_cycle_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] loadVal,
  input  logic       dec,
  output logic [1:0] count,
  output logic       zero
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= 2'd0;
    else if (load) count <= loadVal;
    else if (dec && count != 2'd0) count <= count - 2'd1;
  assign zero = count == 2'd0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and taken-branch flush controller for the 5-stage pipeline
// Inputs: Clk, Reset_n (async active-low), Rs_ID/Rt_ID/UsesRt_ID from ID,
//         MemRead_IDEX/Rt_IDEX from the ID/EX register, BranchTaken_EX from EX.
// Outputs: PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, Busy (state not RUN).
// Optional: define HAZARD_PERF_CNT_EN to add saturating StallCount/FlushCount outputs.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        UsesRt_ID,
  input  logic        MemRead_IDEX,
  input  logic [4:0]  Rt_IDEX,
  input  logic        BranchTaken_EX,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEX_Bubble,
  output logic        IFID_Flush,
  output logic        Busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);
  // The first stall/flush cycle happens in RUN, so the counter only covers the remainder.
  localparam logic [1:0] stallLoad = 2'(clampCycles(LOAD_STALL_CYCLES) - 1);
  localparam logic [1:0] flushLoad = 2'(clampCycles(FLUSH_CYCLES) - 1);
  state_t state, nextState;
  logic [1:0] cnt, loadVal;
  logic cntZero, load, loadUse, lastCycle, stall;
  hazard_cycle_counter cycleCounter (
    .clk(Clk), .rst_n(Reset_n), .load(load), .loadVal(loadVal),
    .dec(state != RUN), .count(cnt), .zero(cntZero)
  );
  assign loadUse = state == RUN && MemRead_IDEX && Rt_IDEX != 5'd0 &&
                   (Rt_IDEX == Rs_ID || (UsesRt_ID && Rt_IDEX == Rt_ID));
  assign lastCycle = cntZero || cnt == 2'd1;
  // A taken branch overrides everything, abandoning any stall on the wrong path.
  always_comb begin
    nextState = BranchTaken_EX ? (flushLoad != 2'd0 ? FLUSH : RUN) :
                loadUse        ? (stallLoad != 2'd0 ? STALL : RUN) :
                (state != RUN && lastCycle) ? RUN : state;
    load    = BranchTaken_EX || loadUse;
    loadVal = BranchTaken_EX ? flushLoad : stallLoad;
    stall   = !BranchTaken_EX && (loadUse || state == STALL);
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= RUN;
    else state <= nextState;
  assign PCWrite     = !stall;
  assign IFIDWrite   = !stall;
  assign IDEX_Bubble = BranchTaken_EX || loadUse || state != RUN;
  assign IFID_Flush  = BranchTaken_EX || state == FLUSH;
  assign Busy        = state != RUN;
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      StallCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      if (!PCWrite && StallCount != 32'hFFFF_FFFF) StallCount <= StallCount + 32'd1;
      if (IFID_Flush && FlushCount != 32'hFFFF_FFFF) FlushCount <= FlushCount + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against a remaining-cycles model
module tb_hazard_ctrl;
  localparam int N = 4;
  localparam int LS [N] = '{1, 2, 3, 2};
  localparam int FC [N] = '{1, 3, 2, 1};
  logic Clk = 1'b0, Reset_n = 1'b0;
  logic [4:0] Rs_ID = 5'd0, Rt_ID = 5'd0, Rt_IDEX = 5'd0;
  logic UsesRt_ID = 1'b0, MemRead_IDEX = 1'b0, BranchTaken_EX = 1'b0;
  logic pcwA [N], ifwA [N], bubA [N], flA [N], busyA [N];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sCnt [N], fCnt [N];
`endif
  int mStall [N], mFlush [N];
  int unsigned mSc [N], mFc [N];
  int checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < N; g++) begin : gDut
    hazard_ctrl #(.LOAD_STALL_CYCLES(LS[g]), .FLUSH_CYCLES(FC[g])) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID),
      .MemRead_IDEX(MemRead_IDEX), .Rt_IDEX(Rt_IDEX), .BranchTaken_EX(BranchTaken_EX),
      .PCWrite(pcwA[g]), .IFIDWrite(ifwA[g]), .IDEX_Bubble(bubA[g]),
      .IFID_Flush(flA[g]), .Busy(busyA[g])
`ifdef HAZARD_PERF_CNT_EN
      , .StallCount(sCnt[g]), .FlushCount(fCnt[g])
`endif
    );
  end

  function automatic logic hazardIn();
    return MemRead_IDEX && Rt_IDEX != 5'd0 && (Rt_IDEX == Rs_ID || (UsesRt_ID && Rt_IDEX == Rt_ID));
  endfunction
  function automatic logic expBusy(int i);
    return mStall[i] > 0 || mFlush[i] > 0;
  endfunction
  function automatic logic expHz(int i);
    return !expBusy(i) && hazardIn();
  endfunction
  function automatic logic expStall(int i);
    return !BranchTaken_EX && (mStall[i] > 0 || expHz(i));
  endfunction
  function automatic logic expFlush(int i);
    return BranchTaken_EX || mFlush[i] > 0;
  endfunction
  function automatic logic [4:0] expOut(int i);
    return {!expStall(i), !expStall(i), BranchTaken_EX || expHz(i) || expBusy(i), expFlush(i), expBusy(i)};
  endfunction
  function automatic logic [4:0] gotOut(int i);
    return {pcwA[i], ifwA[i], bubA[i], flA[i], busyA[i]};
  endfunction

  // Model: counts of stall/flush cycles still owed after the current one.
  always @(posedge Clk or negedge Reset_n)
    for (int i = 0; i < N; i++)
      if (!Reset_n) begin
        mStall[i] <= 0;
        mFlush[i] <= 0;
        mSc[i] <= 0;
        mFc[i] <= 0;
      end else begin
        mSc[i] <= mSc[i] + {31'd0, expStall(i)};
        mFc[i] <= mFc[i] + {31'd0, expFlush(i)};
        mFlush[i] <= BranchTaken_EX ? FC[i] - 1 : mFlush[i] > 0 ? mFlush[i] - 1 : 0;
        mStall[i] <= BranchTaken_EX ? 0 : mStall[i] > 0 ? mStall[i] - 1 : expHz(i) ? LS[i] - 1 : 0;
      end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setIdle();
    MemRead_IDEX = 1'b0;
    BranchTaken_EX = 1'b0;
    UsesRt_ID = 1'b0;
    Rs_ID = 5'd1;
    Rt_ID = 5'd2;
    Rt_IDEX = 5'd3;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    setIdle();
    @(negedge Clk);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gotOut(i) !== 5'b11000) begin
        errors++;
        $display("FAIL reset dut%0d got %b exp %b", i, gotOut(i), 5'b11000);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (sCnt[i] !== 32'd0 || fCnt[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_perf dut%0d got %0d/%0d exp 0/0", i, sCnt[i], fCnt[i]);
      end
`endif
    end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    int stalls [N];
    int busies [N];
    for (int i = 0; i < N; i++) begin
      stalls[i] = 0;
      busies[i] = 0;
    end
    for (int c = 0; c < 6; c++) begin
      setIdle();
      Rt_IDEX = 5'd8;
      Rs_ID = 5'd8;
      MemRead_IDEX = c == 0;
      @(negedge Clk);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (gotOut(i) !== expOut(i)) begin
          errors++;
          $display("FAIL load_use dut%0d cyc%0d got %b exp %b", i, c, gotOut(i), expOut(i));
        end
        stalls[i] += pcwA[i] ? 0 : 1;
        busies[i] += busyA[i] ? 1 : 0;
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (stalls[i] !== LS[i] || busies[i] !== LS[i] - 1) begin
        errors++;
        $display("FAIL load_use_len dut%0d got stall %0d busy %0d exp %0d %0d", i, stalls[i], busies[i], LS[i], LS[i] - 1);
      end
    end
  endtask

  task automatic test_no_hazard();
    logic [4:0] want;
    for (int p = 0; p < 3; p++) begin
      setIdle();
      MemRead_IDEX = 1'b1;
      Rt_IDEX = p == 0 ? 5'd0 : 5'd9;
      Rs_ID = p == 0 ? 5'd0 : 5'd1;
      Rt_ID = p == 0 ? 5'd0 : 5'd9;
      UsesRt_ID = p == 2;
      want = p == 2 ? 5'b00100 : 5'b11000;
      @(negedge Clk);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (gotOut(i) !== want) begin
          errors++;
          $display("FAIL no_hazard dut%0d pat%0d got %b exp %b", i, p, gotOut(i), want);
        end
      end
      tick();
      setIdle();
      repeat (4) tick();
    end
  endtask

  task automatic test_branch_in_stall();
    for (int c = 0; c < 6; c++) begin
      setIdle();
      Rt_IDEX = 5'd5;
      Rs_ID = 5'd5;
      MemRead_IDEX = c == 0;
      BranchTaken_EX = c == 1;
      @(negedge Clk);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (gotOut(i) !== expOut(i)) begin
          errors++;
          $display("FAIL branch_in_stall dut%0d cyc%0d got %b exp %b", i, c, gotOut(i), expOut(i));
        end
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (gotOut(1) !== 5'b11111 || gotOut(3) !== (c == 1 ? 5'b11111 : 5'b11000)) begin
          errors++;
          $display("FAIL branch_in_stall_direct cyc%0d got %b/%b", c, gotOut(1), gotOut(3));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_flush();
    setIdle();
    BranchTaken_EX = 1'b1;
    tick();
    BranchTaken_EX = 1'b0;
    #1;
    checks++;
    if (gotOut(1) !== 5'b11111) begin
      errors++;
      $display("FAIL mid_flush dut1 got %b exp %b", gotOut(1), 5'b11111);
    end
    Reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gotOut(i) !== 5'b11000) begin
        errors++;
        $display("FAIL reset_mid_flush dut%0d got %b exp %b", i, gotOut(i), 5'b11000);
      end
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      setIdle();
      Rt_IDEX = 5'd7;
      Rt_ID = 5'd7;
      UsesRt_ID = 1'b1;
      MemRead_IDEX = c == 0;
      @(negedge Clk);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (gotOut(i) !== expOut(i)) begin
          errors++;
          $display("FAIL after_reset dut%0d cyc%0d got %b exp %b", i, c, gotOut(i), expOut(i));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      Rs_ID = 5'($urandom_range(0, 3));
      Rt_ID = 5'($urandom_range(0, 3));
      Rt_IDEX = 5'($urandom_range(0, 3));
      UsesRt_ID = 1'($urandom_range(0, 1));
      MemRead_IDEX = 1'($urandom_range(0, 1));
      BranchTaken_EX = $urandom_range(0, 7) == 0;
      @(negedge Clk);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (gotOut(i) !== expOut(i)) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d got %b exp %b", i, c, gotOut(i), expOut(i));
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (sCnt[i] !== mSc[i] || fCnt[i] !== mFc[i]) begin
          errors++;
          $display("FAIL random_perf dut%0d got %0d/%0d exp %0d/%0d", i, sCnt[i], fCnt[i], mSc[i], mFc[i]);
        end
`endif
      end
      tick();
    end
    setIdle();
    repeat (4) tick();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    Reset_n = 1'b0;
    setIdle();
    #2;
    Reset_n = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      setIdle();
      if (k < 3) begin
        Rt_IDEX = 5'd4;
        Rs_ID = 5'd4;
        MemRead_IDEX = 1'b1;
      end else BranchTaken_EX = 1'b1;
      tick();
      setIdle();
      repeat (4) tick();
    end
    checks++;
    if (sCnt[3] !== 32'd6 || fCnt[3] !== 32'd2) begin
      errors++;
      $display("FAIL perf dut3 got %0d/%0d exp 6/2", sCnt[3], fCnt[3]);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sCnt[i] !== mSc[i] || fCnt[i] !== mFc[i]) begin
        errors++;
        $display("FAIL perf_model dut%0d got %0d/%0d exp %0d/%0d", i, sCnt[i], fCnt[i], mSc[i], mFc[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_in_stall();
    test_reset_mid_flush();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
